// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, direct-mapped BTB (2-bit counters) and IF/ID register.
// Next PC priority: reset > redirect > halted > stall > predicted next PC.
module fetch_stage #(
    parameter int WORD_SIZE = 16,
    parameter int BTB_IDX_BITS = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 read_m1,
    output logic [WORD_SIZE-1:0] address1,
    input  logic [WORD_SIZE-1:0] data1,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    input  logic                 upd_en,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    output logic [WORD_SIZE-1:0] inst_id,
    output logic [WORD_SIZE-1:0] pc_id,
    output logic [WORD_SIZE-1:0] pc_plus1_id,
    output logic                 pred_taken_id,
    output logic [WORD_SIZE-1:0] pred_target_id,
    output logic                 valid_id,
    output logic                 fetch_halted
);
    localparam int N = 1 << BTB_IDX_BITS;
    localparam int TW = WORD_SIZE - BTB_IDX_BITS;
    localparam logic [WORD_SIZE-1:0] ONE = 1;

    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_next;

    logic [WORD_SIZE-1:0] pc, pc_plus1, pred_next;
    logic                 btb_valid [N];
    logic [TW-1:0]        btb_tag [N];
    logic [WORD_SIZE-1:0] btb_target [N];
    logic [1:0]           btb_cnt [N];

    logic [BTB_IDX_BITS-1:0] idx, uidx;
    logic [TW-1:0]           tag, utag;
    logic                    hit, uhit, pred_taken;

    assign idx = pc[BTB_IDX_BITS-1:0];
    assign tag = pc[WORD_SIZE-1:BTB_IDX_BITS];
    assign uidx = upd_pc[BTB_IDX_BITS-1:0];
    assign utag = upd_pc[WORD_SIZE-1:BTB_IDX_BITS];
    assign hit = btb_valid[idx] && btb_tag[idx] == tag;
    assign uhit = btb_valid[uidx] && btb_tag[uidx] == utag;
    assign pred_taken = hit && btb_cnt[idx][1];
    assign pc_plus1 = pc + ONE;
    assign pred_next = pred_taken ? btb_target[idx] : pc_plus1;

    assign read_m1 = reset_n && !fetch_halted;
    assign address1 = pc;

    always_ff @(posedge clk)
        state <= !reset_n ? RUN : state_next;

    // A redirect alongside halt means the HLT was on the wrong path
    always_comb begin
        state_next = state;
        fetch_halted = state == HALTED;
        if (state == RUN && halt && !redirect)
            state_next = HALTED;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc <= RESET_PC;
            inst_id <= '0;
            pc_id <= '0;
            pc_plus1_id <= '0;
            pred_taken_id <= 1'b0;
            pred_target_id <= '0;
            valid_id <= 1'b0;
        end else if (redirect) begin
            pc <= redirect_pc;
            valid_id <= 1'b0;
        end else if (fetch_halted || halt) begin
            valid_id <= 1'b0;
        end else if (!stall) begin
            pc <= pred_next;
            inst_id <= data1;
            pc_id <= pc;
            pc_plus1_id <= pc_plus1;
            pred_taken_id <= pred_taken;
            pred_target_id <= pred_next;
            valid_id <= 1'b1;
        end
    end

    // Training is independent of stall/halt; same-cycle lookups see the old entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                btb_valid[i] <= 1'b0;
                btb_tag[i] <= '0;
                btb_target[i] <= '0;
                btb_cnt[i] <= 2'b01;
            end
        end else if (upd_en) begin
            if (uhit) begin
                if (upd_taken) begin
                    btb_cnt[uidx] <= btb_cnt[uidx] == 2'b11 ? 2'b11 : btb_cnt[uidx] + 2'd1;
                    btb_target[uidx] <= upd_target;
                end else begin
                    btb_cnt[uidx] <= btb_cnt[uidx] == 2'b00 ? 2'b00 : btb_cnt[uidx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_valid[uidx] <= 1'b1;
                btb_tag[uidx] <= utag;
                btb_target[uidx] <= upd_target;
                btb_cnt[uidx] <= 2'b10;
            end
        end
    end
endmodule
